// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block controller.
//   state_t     : controller FSM states
//   H_INIT      : SHA-256 initial chaining values H0..H7
//   WORD_W      : message/digest word width
//   BLOCK_WORDS : message words per 512-bit block
package sha256_pkg;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, WAIT, UPDATE, OUT} state_t;

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
endpackage

// File: rtl/sha256_block_ctrl_if.sv
// Handshake/bus bundle between the SHA-256 block controller and its
// neighbours (message source, round Generator, digest sink).
//   slave  : controller side
//   master : environment side (source, Generator, sink)
interface sha256_block_ctrl_if;
  import sha256_pkg::*;

  logic                  start;
  logic                  word_valid;
  logic [WORD_W-1:0]     word_in;
  logic                  word_last;
  logic                  word_ready;
  logic                  gen_run;
  logic [5:0]            gen_round;
  logic [WORD_W-1:0]     gen_word;
  logic [8*WORD_W-1:0]   gen_state;
  logic                  gen_rdy;
  logic [8*WORD_W-1:0]   gen_result;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [WORD_W-1:0]     dout;
  logic                  busy;
  logic                  err;

  modport slave (
    input  start, word_valid, word_in, word_last, gen_rdy, gen_result, dout_ready,
    output word_ready, gen_run, gen_round, gen_word, gen_state, dout_valid, dout, busy, err
  );

  modport master (
    output start, word_valid, word_in, word_last, gen_rdy, gen_result, dout_ready,
    input  word_ready, gen_run, gen_round, gen_word, gen_state, dout_valid, dout, busy, err
  );
endinterface

// File: rtl/sha256_word_buf.sv
// 16 x 32 message word buffer.
//   clk, rst  : clock, synchronous active-high clear
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module sha256_word_buf
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencing controller: buffers a block of message words,
// walks the Generator through the rounds, feeds the result forward into
// H0..H7, chains blocks and finally streams the 8-word digest.
//   clk, rst_n : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   bus        : sha256_block_ctrl_if.slave (message in, Generator, digest out)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting 16 message words into the buffer
// ROUND  | presenting round index/word to the Generator, one per cycle
// WAIT   | waiting (bounded) for Generator result
// UPDATE | feed-forward add into H0..H7
// OUT    | streaming digest words H0..H7
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int GEN_TIMEOUT = 15,
  parameter int ROUNDS      = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  sha256_block_ctrl_if.slave  bus
);
  localparam int          TMR_W      = $clog2(GEN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GEN_TIMEOUT - 1);
  localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);

  state_t               state;
  logic [3:0]           cnt;
  logic [TMR_W-1:0]     tmr;
  logic [2:0]           k;
  logic                 last_f;
  logic [WORD_W-1:0]    h     [8];
  logic [WORD_W-1:0]    res   [8];
  logic [WORD_W-1:0]    h_sum [8];
  logic [8*WORD_W-1:0]  h_cat;

  logic                 word_ready_q, gen_run_q, dout_valid_q, busy_q, err_q;
  logic [5:0]           gen_round_q;
  logic [8*WORD_W-1:0]  gen_state_q;
  logic [WORD_W-1:0]    dout_q;
  logic [WORD_W-1:0]    buf_rdata;
  logic                 buf_we;

  assign buf_we = (state == LOAD) && bus.word_valid && word_ready_q;

  sha256_word_buf u_buf (
    .clk   (clk),
    .rst   (rst_n),
    .we    (buf_we),
    .waddr (cnt),
    .wdata (bus.word_in),
    .raddr (gen_round_q[3:0]),
    .rdata (buf_rdata)
  );

  // Feed-forward: independent mod-2^32 adds, no carry between words.
  always_comb begin
    h_cat = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h[i] + res[i];
      h_cat[(8*WORD_W-1) - WORD_W*i -: WORD_W] = h[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tmr          <= '0;
      k            <= '0;
      last_f       <= 1'b0;
      word_ready_q <= 1'b0;
      gen_run_q    <= 1'b0;
      gen_round_q  <= '0;
      gen_state_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h[i]   <= H_INIT[i];
        res[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LOAD;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            cnt          <= '0;
            for (int i = 0; i < 8; i++) h[i] <= H_INIT[i];
          end
        end
        LOAD: begin
          if (bus.word_valid && word_ready_q) begin
            if (cnt == 4'(BLOCK_WORDS - 1)) begin
              cnt          <= '0;
              last_f       <= bus.word_last;
              word_ready_q <= 1'b0;
              gen_run_q    <= 1'b1;
              gen_round_q  <= '0;
              // Working-variable init is frozen for the whole block.
              gen_state_q  <= h_cat;
              state        <= ROUND;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        ROUND: begin
          if (gen_round_q == LAST_ROUND) begin
            gen_run_q   <= 1'b0;
            gen_round_q <= '0;
            tmr         <= TMR_LOAD;
            state       <= WAIT;
          end else begin
            gen_round_q <= gen_round_q + 6'd1;
          end
        end
        WAIT: begin
          if (bus.gen_rdy) begin
            for (int i = 0; i < 8; i++)
              res[i] <= bus.gen_result[(8*WORD_W-1) - WORD_W*i -: WORD_W];
            state <= UPDATE;
          end else if (tmr == '0) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h[i] <= h_sum[i];
          if (last_f) begin
            state        <= OUT;
            dout_valid_q <= 1'b1;
            dout_q       <= h_sum[0];
            k            <= '0;
          end else begin
            state        <= LOAD;
            word_ready_q <= 1'b1;
          end
        end
        OUT: begin
          if (bus.dout_ready) begin
            if (k == 3'd7) begin
              dout_valid_q <= 1'b0;
              dout_q       <= '0;
              busy_q       <= 1'b0;
              state        <= IDLE;
            end else begin
              k      <= k + 3'd1;
              dout_q <= h[k + 3'd1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.word_ready = word_ready_q;
  assign bus.gen_run    = gen_run_q;
  assign bus.gen_round  = gen_round_q;
  assign bus.gen_word   = (gen_run_q && (gen_round_q < 6'(BLOCK_WORDS))) ? buf_rdata : '0;
  assign bus.gen_state  = gen_state_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_sha256_block_ctrl.sv
module tb_sha256_block_ctrl;
  logic clk;
  logic rst_n;
  sha256_block_ctrl_if bus ();

  sha256_block_ctrl #(.GEN_TIMEOUT(15), .ROUNDS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  bit gen_en = 1'b1;
  int run_cnt = 0;

  logic [31:0] msg_abc [16];
  logic [31:0] msg2a   [16];
  logic [31:0] msg2b   [16];
  logic [31:0] dig_abc [8];
  logic [31:0] dig_two [8];

  logic [31:0] kc [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Generator reference: 64 compression rounds without the feed-forward add.
  function automatic logic [255:0] compress(input logic [255:0] st, input logic [31:0] w16 [16]);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = w16[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kc[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  // Generator model: collects round inputs, answers one cycle after round 63.
  initial begin : gen_model
    logic [255:0] m_state;
    logic [31:0]  m_w [16];
    bit           m_last;
    m_state = '0;
    m_last  = 1'b0;
    for (int i = 0; i < 16; i++) m_w[i] = '0;
    bus.gen_rdy    = 1'b0;
    bus.gen_result = '0;
    forever begin
      @(negedge clk);
      bus.gen_rdy = 1'b0;
      if (bus.gen_run) begin
        if (bus.gen_round == 6'd0) m_state = bus.gen_state;
        if (bus.gen_round < 6'd16) m_w[bus.gen_round[3:0]] = bus.gen_word;
        m_last = (bus.gen_round == 6'd63);
        run_cnt++;
      end else if (m_last) begin
        m_last = 1'b0;
        if (gen_en) begin
          bus.gen_result = compress(m_state, m_w);
          bus.gen_rdy    = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic lst);
    int n = 0;
    while (!bus.word_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.word_ready !== 1'b1) begin
      bad++;
      $display("FAIL word_ready_wait: got %b want 1", bus.word_ready);
    end
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    bus.word_last  = lst;
    @(negedge clk);
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
    bus.word_in    = '0;
  endtask

  task automatic send_block(input logic [31:0] m [16], input bit lst);
    for (int i = 0; i < 16; i++) send_word(m[i], lst && (i == 15));
  endtask

  task automatic push_digest(input logic [31:0] d [8]);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
  endtask

  // Drains the digest stream, popping the scoreboard on each handshake.
  task automatic collect_out(input bit bp, input string tag);
    int n = 0, hs = 0, ph = 0;
    bit holding = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] e;
    while (hs < 8 && n < 600) begin
      if (holding && bus.dout_valid) begin
        total++;
        if (bus.dout !== held) begin
          bad++;
          $display("FAIL %s_dout_hold: got %h want %h", tag, bus.dout, held);
        end
      end
      holding = 1'b0;
      if (bus.dout_valid) begin
        bus.dout_ready = bp ? ((ph % 3) == 0) : 1'b1;
        ph++;
        if (bus.dout_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_dout_extra: got %h want none", tag, bus.dout);
          end else begin
            e = exp_q.pop_front();
            if (bus.dout !== e) begin
              bad++;
              $display("FAIL %s_dout[%0d]: got %h want %h", tag, hs, bus.dout, e);
            end
          end
          hs++;
        end else begin
          holding = 1'b1;
          held    = bus.dout;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.dout_ready = 1'b1;
    total++;
    if (hs != 8) begin
      bad++;
      $display("FAIL %s_handshakes: got %0d want 8", tag, hs);
    end
    total++;
    if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_end_idle: got valid=%b busy=%b want 0 0", tag, bus.dout_valid, bus.busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.word_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b err=%b rdy=%b want 0 0 0", bus.busy, bus.err, bus.word_ready);
    end
    total++;
    if (bus.gen_run !== 1'b0 || bus.gen_round !== 6'd0 || bus.gen_word !== 32'd0) begin
      bad++;
      $display("FAIL reset_gen: got run=%b rnd=%0d w=%h want 0 0 0", bus.gen_run, bus.gen_round, bus.gen_word);
    end
    total++;
    if (bus.gen_state !== 256'd0) begin
      bad++;
      $display("FAIL reset_gen_state: got %h want 0", bus.gen_state);
    end
    total++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 32'd0) begin
      bad++;
      $display("FAIL reset_dout: got v=%b d=%h want 0 0", bus.dout_valid, bus.dout);
    end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abc();
    int n = 0;
    bit busy_ok = 1'b1;
    pulse_start();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL abc_busy_after_start: got %b want 1", bus.busy);
    end
    push_digest(dig_abc);
    send_block(msg_abc, 1'b1);
    // Now in round 0: 64 rounds + WAIT + UPDATE before the first digest word.
    while (!bus.dout_valid && n < 300) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 66) begin
      bad++;
      $display("FAIL abc_latency: got %0d want 66", n);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL abc_busy_hold: got 0 want 1");
    end
    collect_out(1'b0, "abc");
  endtask

  task automatic test_two_block();
    int r0 = run_cnt;
    pulse_start();
    push_digest(dig_two);
    send_block(msg2a, 1'b0);
    send_block(msg2b, 1'b1);
    collect_out(1'b0, "two");
    total++;
    if (run_cnt - r0 != 128) begin
      bad++;
      $display("FAIL two_gen_run_cycles: got %0d want 128", run_cnt - r0);
    end
  endtask

  task automatic test_backpressure();
    pulse_start();
    push_digest(dig_abc);
    send_block(msg_abc, 1'b1);
    collect_out(1'b1, "bp");
  endtask

  task automatic test_gap_start();
    pulse_start();
    push_digest(dig_abc);
    for (int i = 0; i < 8; i++) send_word(msg_abc[i], 1'b0);
    for (int g = 0; g < 3; g++) begin
      total++;
      if (bus.word_ready !== 1'b1 || bus.gen_run !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold: got rdy=%b run=%b want 1 0", bus.word_ready, bus.gen_run);
      end
      @(negedge clk);
    end
    for (int i = 8; i < 15; i++) send_word(msg_abc[i], 1'b1);
    total++;
    if (bus.gen_run !== 1'b0) begin
      bad++;
      $display("FAIL gap_early_round: got %b want 0", bus.gen_run);
    end
    send_word(msg_abc[15], 1'b1);
    total++;
    if (bus.gen_run !== 1'b1 || bus.gen_round !== 6'd0) begin
      bad++;
      $display("FAIL gap_round_start: got run=%b rnd=%0d want 1 0", bus.gen_run, bus.gen_round);
    end
    repeat (10) @(negedge clk);
    pulse_start();
    total++;
    if (bus.busy !== 1'b1 || bus.word_ready !== 1'b0 || bus.gen_run !== 1'b1 || bus.gen_round !== 6'd11) begin
      bad++;
      $display("FAIL stray_start: got busy=%b rdy=%b run=%b rnd=%0d want 1 0 1 11",
               bus.busy, bus.word_ready, bus.gen_run, bus.gen_round);
    end
    collect_out(1'b0, "gap");
  endtask

  task automatic test_timeout();
    int n = 0;
    gen_en = 1'b0;
    pulse_start();
    send_block(msg_abc, 1'b1);
    while (bus.gen_run && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.err && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 15) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d want 15", n);
    end
    total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: got err=%b busy=%b v=%b want 1 0 0", bus.err, bus.busy, bus.dout_valid);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got %b want 1", bus.err);
    end
    gen_en = 1'b1;
    pulse_start();
    total++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL err_clear: got err=%b busy=%b want 0 1", bus.err, bus.busy);
    end
    push_digest(dig_abc);
    send_block(msg_abc, 1'b1);
    collect_out(1'b0, "after_to");
  endtask

  task automatic test_reset_mid_round();
    int n = 0;
    pulse_start();
    send_block(msg_abc, 1'b1);
    while (!(bus.gen_run && bus.gen_round == 6'd30) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.gen_round !== 6'd30) begin
      bad++;
      $display("FAIL rst_reach_round30: got %0d want 30", bus.gen_round);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.gen_run !== 1'b0 || bus.dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_round: got busy=%b run=%b v=%b want 0 0 0", bus.busy, bus.gen_run, bus.dout_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    pulse_start();
    push_digest(dig_abc);
    send_block(msg_abc, 1'b1);
    collect_out(1'b0, "after_rst");
  endtask

  initial begin
    msg_abc = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
    msg2a   = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    msg2b   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};
    dig_abc = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    dig_two = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    rst_n          = 1'b1;
    bus.start      = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    bus.word_last  = 1'b0;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_abc();
    test_two_block();
    test_backpressure();
    test_gap_start();
    test_timeout();
    test_reset_mid_round();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha256_block_ctrl.md
Name: sha256_block_ctrl

Overview:
- Sequencing controller for the SHA-256 compression datapath.
- Buffers 16 message words per 512-bit block and drives the Generator round index for 64 rounds.
- Owns the H0..H7 chaining registers and performs the feed-forward add; chains multiple blocks.
- After the last block, streams the 8-word digest out serially, replacing ad-hoc calcu_en/read_en sequencing at the Sha256 top level.

Parameters:
- GEN_TIMEOUT, 15: max cycles in WAIT for gen_rdy before abort.
- ROUNDS, 64: rounds per block (fixed 64 in product; override for bench only).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset. Synchronous, active-high despite the codebase name: rst_n==1 at a rising edge resets.
- start  input  1  pulse: begin a new message; accepted only in IDLE.
- word_valid  input  1  message word present.
- word_in  input  32  message word, W0 first.
- word_last  input  1  qualifies the 16th word of a block: this block is the final one.
- word_ready  output  1  controller accepts word_in this cycle.
- gen_run  output  1  round index valid to Generator.
- gen_round  output  6  round index 0..63.
- gen_word  output  32  Wt for t<16 from the buffer; 0 for t>=16.
- gen_state  output  256  {H0..H7} as working-variable init.
- gen_rdy  input  1  Generator result valid.
- gen_result  input  256  {A..H} after round 63 (A already summed).
- dout_valid  output  1  digest word valid.
- dout_ready  input  1  sink accepts digest word.
- dout  output  32  digest word, H0 first.
- busy  output  1  state != IDLE.
- err  output  1  sticky timeout flag; cleared by start or reset.

Behaviour:
- Reset: state=IDLE; all outputs 0; H regs = FIPS initial constants (6a09e667..5be0cd19); word count, round count, buffer and last flag = 0.
- IDLE:
  - start=1 -> LOAD; H <= initial constants; err <= 0.
  - word_valid is ignored.
- LOAD:
  - word_ready=1. Each word_valid&word_ready writes buf[cnt] and increments cnt.
  - On the 16th word: latch word_last into last_f; cnt wraps to 0; go to ROUND next cycle.
  - word_last on words 1..15 is ignored.
- ROUND:
  - word_ready=0; gen_run=1; gen_round = 0..63, one per cycle; no stall.
  - gen_word = buf[gen_round] when gen_round<16, else 0.
  - gen_state is held stable for the whole block.
  - After round 63 -> WAIT.
- WAIT:
  - gen_run=0. gen_rdy=1 -> UPDATE, with gen_result captured that cycle.
  - Timeout: after GEN_TIMEOUT cycles without gen_rdy, set err=1 and go to IDLE with H unchanged.
  - gen_rdy seen in any other state is ignored.
- UPDATE (1 cycle):
  - Hi <= Hi + result_i, mod 2^32 per word, no carry between words.
  - Then last_f=1 -> OUT, else -> LOAD.
- OUT:
  - dout_valid=1; dout = H[k], k = 0..7.
  - k advances only on dout_valid&dout_ready; dout holds stable while stalled.
  - After the k=7 handshake -> IDLE with dout_valid=0.
  - H retains the digest until the next start.
- start outside IDLE is ignored; no restart mid-message.
- Reset asserted in any state returns to IDLE at that edge; partial buffer contents are discarded.
- Minimum latency per block, with gen_rdy arriving 1 cycle after round 63:
  - LOAD 16 cycles, ROUND 64, WAIT 1, UPDATE 1.
  - Final block adds 8 cycles of OUT with dout_ready tied high.

Decomposition:
- Shared package sha256_pkg:
  - state enum {IDLE, LOAD, ROUND, WAIT, UPDATE, OUT}.
  - H_INIT[0:7] constants, same values as InitialConstant.
  - WORD_W=32, BLOCK_WORDS=16.
- One sub-module: sha256_word_buf, a 16x32 register file with write port (en, addr, data) and combinational read port.
- The feed-forward add stays inline as eight 32-bit adders; ThirtytwobitAdder instances are acceptable.

Test Plan:
- "abc" single block: pulse start, then 16 words 61626380, 0x0 x14, 00000018, with word_last on word 16. Required: 8 dout words ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; busy=1 from the cycle after start until after the last dout handshake.
- Two-block 448-bit "abcdbcdecdef...nopq" message, word_last only on word 32. Required: dout 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; gen_run runs exactly 128 cycles total.
- Backpressure: dout_ready toggles 1,0,0,1,... during OUT. Required: dout holds while dout_ready=0; 8 handshakes total; word order unchanged.
- Gaps and ignored start: word_valid deasserted for 3 cycles mid-LOAD, and start pulsed during ROUND. Required: cnt freezes during the gap; digest is identical to the "abc" result; the stray start has no effect.
- Timeout: Generator model never asserts gen_rdy. Required: err=1 exactly GEN_TIMEOUT cycles after WAIT entry; state returns to IDLE; the next start clears err.
- Reset mid-ROUND at round 30. Required: on the next edge busy=0, gen_run=0, dout_valid=0. A subsequent "abc" run gives the correct digest.
